apb_master_arbiter: RTL

APB master that shares one APB bus among `NUM_REQ` internal requesters (e.g. I2C controller, host port) and sequences every transfer through IDLE → SETUP → ACCESS. It selects the target `APB_Slave_with_mem` by slave id and stretches ACCESS on `pready` low, which covers memory wait states. A timeout guards against hung slaves. It sits between the requesters and the shared `APB_Bus` signals.

---
 rtl/apb_master_arbiter_pkg.sv | 24 ++
 rtl/apb_master_arbiter_if.sv | 39 +++
 rtl/apb_master_arbiter_rr_arbiter.sv | 55 +++++
 rtl/apb_master_arbiter.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/apb_master_arbiter_pkg.sv
// Shared types for the APB master/arbiter: FSM state encoding, default bus widths
// and the record that holds a granted request for the duration of its transfer.
package apb_pkg;

  localparam int DEF_NUM_SLV = 4;
  localparam int DEF_ID_W    = $clog2(DEF_NUM_SLV);
  localparam int DEF_ADDR_W  = 8;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_t;

  // Sized by the package defaults; widening the bus means widening these too.
  typedef struct packed {
    logic                  write;
    logic [DEF_ID_W-1:0]   id;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } apb_req_t;

endpackage

// File: rtl/apb_master_arbiter_if.sv
// APB bus bundle between the master/arbiter (master modport) and the
// memory-backed slaves (slave modport).
interface apb_master_arbiter_if
  import apb_pkg::*;
#(
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W
);

  logic [NUM_SLV-1:0] psel;
  logic               penable;
  logic               pwrite;
  logic [ADDR_W-1:0]  paddr;
  logic [DATA_W-1:0]  pwdata;
  logic [DATA_W-1:0]  prdata;
  logic               pready;

  modport master (
    output psel,
    output penable,
    output pwrite,
    output paddr,
    output pwdata,
    input  prdata,
    input  pready
  );

  modport slave (
    input  psel,
    input  penable,
    input  pwrite,
    input  paddr,
    input  pwdata,
    output prdata,
    output pready
  );

endinterface

// File: rtl/apb_master_arbiter_rr_arbiter.sv
// Round-robin arbiter: combinational winner from a rotating priority pointer.
// The pointer moves past the winner only when i_advance (the grant) is high.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] i_req,
  input  logic               i_advance,
  output logic               o_any,
  output logic [PTR_W-1:0]   o_win,
  output logic [NUM_REQ-1:0] o_grant
);

  localparam int unsigned N = NUM_REQ;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_cand [NUM_REQ];
  logic [PTR_W-1:0] w_win;

  function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] base,
                                                input int unsigned      off);
    int unsigned s;
    s = 32'(base) + off;
    if (s >= N) s = s - N;
    return PTR_W'(s);
  endfunction

  // w_cand[k] is the requester holding priority rank k (0 = highest).
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign w_cand[gi] = wrap_idx(r_ptr, gi);
  end

  // Scan from lowest to highest rank so the highest-ranked request wins.
  always_comb begin
    w_win = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (i_req[w_cand[k]]) w_win = w_cand[k];
    end
  end

  assign o_any   = |i_req;
  assign o_win   = w_win;
  assign o_grant = o_any ? (NUM_REQ'(1) << w_win) : '0;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (i_advance) begin
      r_ptr <= wrap_idx(w_win, 1);
    end
  end

endmodule

// File: rtl/apb_master_arbiter.sv
// APB master shared by NUM_REQ requesters: round-robin grant, IDLE/SETUP/ACCESS
// sequencing, wait-state stretching and a timeout that aborts hung transfers.
module apb_master_arbiter
  import apb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int NUM_SLV = DEF_NUM_SLV,
  parameter int ID_W    = $clog2(NUM_SLV),
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 15
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ID_W-1:0]   req_id,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      err,
  apb_master_arbiter_if.master      apb
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  apb_state_t         r_state, w_state_next;
  apb_req_t           r_req, w_req_next;
  logic [PTR_W-1:0]   r_owner, w_owner_next;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [NUM_REQ-1:0] r_gnt, w_gnt_next;
  logic [NUM_REQ-1:0] r_done, w_done_next;
  logic [DATA_W-1:0]  r_rdata, w_rdata_next;
  logic               r_err, w_err_next;
  logic [NUM_SLV-1:0] r_psel, w_psel_next;
  logic               r_penable, w_penable_next;

  logic               w_take;
  logic               w_finish;
  logic               w_arb_any;
  logic [PTR_W-1:0]   w_arb_win;
  logic [NUM_REQ-1:0] w_arb_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_arbiter (
    .clk       (clk),
    .reset     (reset),
    .i_req     (req),
    .i_advance (w_take),
    .o_any     (w_arb_any),
    .o_win     (w_arb_win),
    .o_grant   (w_arb_grant)
  );

  always_comb begin
    w_state_next   = r_state;
    w_req_next     = r_req;
    w_owner_next   = r_owner;
    w_cnt_next     = r_cnt;
    w_gnt_next     = '0;
    w_done_next    = '0;
    w_rdata_next   = r_rdata;
    w_err_next     = r_err;
    w_psel_next    = r_psel;
    w_penable_next = r_penable;
    w_take         = 1'b0;
    w_finish       = 1'b0;

    unique case (r_state)
      IDLE: begin
        w_take = w_arb_any;
      end
      SETUP: begin
        w_state_next   = ACCESS;
        w_penable_next = 1'b1;
        w_psel_next    = NUM_SLV'(1) << r_req.id;
      end
      ACCESS: begin
        // pready on the timeout edge still counts as a normal completion.
        if (apb.pready) begin
          w_finish   = 1'b1;
          w_err_next = 1'b0;
          if (!r_req.write) w_rdata_next = apb.prdata;
        end else if (r_cnt == TIMEOUT_C) begin
          w_finish     = 1'b1;
          w_err_next   = 1'b1;
          w_rdata_next = '0;
        end else begin
          w_cnt_next = r_cnt + CNT_W'(1);
        end

        if (w_finish) begin
          w_done_next[r_owner] = 1'b1;
          w_take               = w_arb_any;
          if (!w_arb_any) begin
            w_state_next   = IDLE;
            w_psel_next    = '0;
            w_penable_next = 1'b0;
          end
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    // A grant from IDLE or straight out of ACCESS lands in SETUP.
    if (w_take) begin
      w_state_next     = SETUP;
      w_gnt_next       = w_arb_grant;
      w_owner_next     = w_arb_win;
      w_req_next.write = req_write[w_arb_win];
      w_req_next.id    = req_id[w_arb_win*ID_W +: ID_W];
      w_req_next.addr  = req_addr[w_arb_win*ADDR_W +: ADDR_W];
      w_req_next.wdata = req_wdata[w_arb_win*DATA_W +: DATA_W];
      w_psel_next      = NUM_SLV'(1) << req_id[w_arb_win*ID_W +: ID_W];
      w_penable_next   = 1'b0;
      w_cnt_next       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= IDLE;
      r_req     <= '0;
      r_owner   <= '0;
      r_cnt     <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_err     <= 1'b0;
      r_psel    <= '0;
      r_penable <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_req     <= w_req_next;
      r_owner   <= w_owner_next;
      r_cnt     <= w_cnt_next;
      r_gnt     <= w_gnt_next;
      r_done    <= w_done_next;
      r_rdata   <= w_rdata_next;
      r_err     <= w_err_next;
      r_psel    <= w_psel_next;
      r_penable <= w_penable_next;
    end
  end

  assign gnt         = r_gnt;
  assign done        = r_done;
  assign rdata       = r_rdata;
  assign err         = r_err;
  assign apb.psel    = r_psel;
  assign apb.penable = r_penable;
  assign apb.pwrite  = r_req.write;
  assign apb.paddr   = r_req.addr;
  assign apb.pwdata  = r_req.wdata;

endmodule
